// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared constants, scan states and key code map for the keypad scanner
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int CODE_W   = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_PUSH  = 2'd2
    } scan_state_e;

    // Index is row*4+col; the map follows the printed legend of the wb_key keypad.
    function automatic logic [CODE_W-1:0] key_code_of(input logic [3:0] idx);
        logic [CODE_W-1:0] c;
        case (idx)
            4'd0:    c = 5'd1;
            4'd1:    c = 5'd2;
            4'd2:    c = 5'd3;
            4'd3:    c = 5'd10;
            4'd4:    c = 5'd4;
            4'd5:    c = 5'd5;
            4'd6:    c = 5'd6;
            4'd7:    c = 5'd11;
            4'd8:    c = 5'd7;
            4'd9:    c = 5'd8;
            4'd10:   c = 5'd9;
            4'd11:   c = 5'd12;
            4'd12:   c = 5'd14;
            4'd13:   c = 5'd0;
            4'd14:   c = 5'd15;
            default: c = 5'd13;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// rtl/keypad_scan_ctrl_if.sv - key event bus between the scanner and the register side
interface keypad_scan_ctrl_if;
    import keypad_pkg::*;

    logic              key_valid;
    logic [CODE_W-1:0] key_code;
    logic              key_pop;
    logic              overflow;
    logic              ovf_clr;
    logic              irq;

    modport master (
        output key_valid, key_code, overflow, irq,
        input  key_pop, ovf_clr
    );

    modport slave (
        input  key_valid, key_code, overflow, irq,
        output key_pop, ovf_clr
    );

endinterface

// File: rtl/key_event_fifo.sv
// rtl/key_event_fifo.sv - show-ahead event FIFO with registered head and sticky drop flag
module key_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    input  logic             i_ovf_clr,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_head,
    output logic             o_overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_head;
    logic             r_overflow;

    logic          w_empty;
    logic          w_full;
    logic          w_do_pop;
    logic          w_do_push;
    logic          w_drop;
    logic [AW-1:0] w_rd_inc;
    logic [AW-1:0] w_wr_inc;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = i_pop && !w_empty;
    // A pop frees the slot this cycle, so a push on a full FIFO still lands.
    assign w_do_push = i_push && (!w_full || w_do_pop);
    assign w_drop    = i_push && !w_do_push;
    assign w_rd_inc  = (r_rd == AW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
    assign w_wr_inc  = (r_wr == AW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr       <= '0;
            r_rd       <= '0;
            r_count    <= '0;
            r_head     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_do_push) r_wr <= w_wr_inc;
            if (w_do_pop)  r_rd <= w_rd_inc;
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
            if (w_do_pop) begin
                if (r_count == CW'(1)) begin
                    if (w_do_push) r_head <= i_push_data;
                end else begin
                    r_head <= r_mem[w_rd_inc];
                end
            end else if (w_do_push && w_empty) begin
                r_head <= i_push_data;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign o_valid    = !w_empty;
    assign o_head     = r_head;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - 4x4 keypad row scanner with frame debounce and press event queue
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [NUM_COLS-1:0] columnas,
    output logic [NUM_ROWS-1:0] filas,
    keypad_scan_ctrl_if.master  bus
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int MW = $clog2(DEBOUNCE_SCANS + 1);
    localparam int NK = NUM_ROWS * NUM_COLS;

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_DRIVE = ST_DRIVE;
    localparam logic [1:0] S_PUSH  = ST_PUSH;

    logic [1:0]          r_state;
    logic [NUM_COLS-1:0] r_col_s1;
    logic [NUM_COLS-1:0] r_col_s2;
    logic [1:0]          r_row;
    logic [DW-1:0]       r_dwell;
    logic [3:0]          r_k;
    logic [NK-1:0]       r_frame;
    logic [NK-1:0]       r_prev;
    logic [NK-1:0]       r_stable;
    logic [NK-1:0]       r_pressed;
    logic [MW-1:0]       r_match;

    logic [NK-1:0]     w_frame_new;
    logic [MW-1:0]     w_match_next;
    logic              w_dwell_end;
    logic              w_push;
    logic [CODE_W-1:0] w_push_code;

    always_comb begin
        w_frame_new = r_frame;
        w_frame_new[{r_row, 2'b00} +: NUM_COLS] = r_col_s2;
        if ((w_frame_new != r_stable) && (w_frame_new == r_prev)) begin
            w_match_next = r_match + 1'b1;
        end else begin
            w_match_next = MW'(1);
        end
    end

    assign w_dwell_end = (r_state == S_DRIVE) && (r_dwell == DW'(SCAN_DIV - 1));
    assign w_push      = (r_state == S_PUSH) && r_pressed[r_k];
    assign w_push_code = key_code_of(r_k);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_col_s1  <= '0;
            r_col_s2  <= '0;
            r_row     <= '0;
            r_dwell   <= '0;
            r_k       <= '0;
            r_frame   <= '0;
            r_prev    <= '0;
            r_stable  <= '0;
            r_pressed <= '0;
            r_match   <= '0;
        end else begin
            r_col_s1 <= columnas;
            r_col_s2 <= r_col_s1;
            // Losing enable abandons the partial frame; stable keys and queued events survive.
            if (!enable) begin
                r_state <= S_IDLE;
                r_row   <= '0;
                r_dwell <= '0;
                r_k     <= '0;
                r_frame <= '0;
                r_match <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_DRIVE;
                        r_row   <= '0;
                        r_dwell <= '0;
                    end
                    S_DRIVE: begin
                        if (w_dwell_end) begin
                            r_dwell <= '0;
                            r_frame <= w_frame_new;
                            if (r_row == 2'd3) begin
                                r_state <= S_PUSH;
                                r_row   <= '0;
                                r_k     <= '0;
                                r_prev  <= w_frame_new;
                                if (w_match_next == MW'(DEBOUNCE_SCANS)) begin
                                    r_pressed <= w_frame_new & ~r_stable;
                                    r_stable  <= w_frame_new;
                                    r_match   <= '0;
                                end else begin
                                    r_pressed <= '0;
                                    r_match   <= w_match_next;
                                end
                            end else begin
                                r_row <= r_row + 1'b1;
                            end
                        end else begin
                            r_dwell <= r_dwell + 1'b1;
                        end
                    end
                    S_PUSH: begin
                        r_k <= r_k + 1'b1;
                        if (r_k == 4'd15) r_state <= S_DRIVE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign filas = (r_state == S_DRIVE) ? (NUM_ROWS'(1) << r_row) : '0;

    key_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CODE_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_code),
        .i_pop       (bus.key_pop),
        .i_ovf_clr   (bus.ovf_clr),
        .o_valid     (bus.key_valid),
        .o_head      (bus.key_code),
        .o_overflow  (bus.overflow)
    );

    assign bus.irq = bus.key_valid;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb/tb_keypad_scan_ctrl.sv - self-checking bench for keypad_scan_ctrl with a frame-level model
module tb_keypad_scan_ctrl;

    localparam int SD    = 4;
    localparam int DEB   = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [3:0]  columnas;
    logic [3:0]  filas;
    logic [15:0] held;

    int checks = 0;
    int errors = 0;

    int code_tab [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    logic [15:0] m_stable;
    logic [15:0] m_prev;
    int          m_cnt;
    logic        m_ovf;
    logic [4:0]  m_q [$];

    keypad_scan_ctrl_if bus ();

    keypad_scan_ctrl #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_SCANS (DEB),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .columnas (columnas),
        .filas    (filas),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Physical keypad: a held key connects its row line to its column line.
    always_comb begin
        columnas = 4'b0000;
        for (int r = 0; r < 4; r++) begin
            if (filas[r]) columnas |= held[r*4 +: 4];
        end
    end

    task automatic model_frame(input logic [15:0] h);
        if ((h != m_stable) && (h == m_prev)) m_cnt++;
        else m_cnt = 1;
        if (m_cnt == DEB) begin
            for (int i = 0; i < 16; i++) begin
                if (h[i] && !m_stable[i]) begin
                    if (m_q.size() < DEPTH) m_q.push_back(5'(code_tab[i]));
                    else m_ovf = 1'b1;
                end
            end
            m_stable = h;
            m_cnt    = 0;
        end
        m_prev = h;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        enable      = 1'b0;
        held        = '0;
        bus.key_pop = 1'b0;
        bus.ovf_clr = 1'b0;
        m_stable    = '0;
        m_prev      = '0;
        m_cnt       = 0;
        m_ovf       = 1'b0;
        m_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_filas(input logic [3:0] v);
        int n = 0;
        while (filas !== v && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (filas !== v) begin
            checks++;
            errors++;
            $display("FAIL wait_filas timeout got %b exp %b", filas, v);
        end
    endtask

    // Returns on the first PUSH cycle of the frame that saw h.
    task automatic do_frame(input logic [15:0] h, input bit pop_at_push);
        held = h;
        wait_filas(4'b1000);
        wait_filas(4'b0000);
        if (pop_at_push) begin
            bus.key_pop = 1'b1;
            if (m_q.size() > 0) m_q.delete(0);
        end
        model_frame(h);
        if (pop_at_push) begin
            @(negedge clk);
            bus.key_pop = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        logic [4:0] exp;
        repeat (17) @(negedge clk);
        enable = 1'b0;
        m_cnt  = 0;
        @(negedge clk);
        checks++;
        if (bus.overflow !== m_ovf) begin
            errors++;
            $display("FAIL %s_overflow got %b exp %b", name, bus.overflow, m_ovf);
        end
        while (m_q.size() > 0) begin
            exp = m_q.pop_front();
            checks++;
            if (bus.key_valid !== 1'b1 || bus.key_code !== exp) begin
                errors++;
                $display("FAIL %s_event got valid=%b code=%0d exp code=%0d", name, bus.key_valid, bus.key_code, exp);
            end
            bus.key_pop = 1'b1;
            @(negedge clk);
            bus.key_pop = 1'b0;
        end
        checks++;
        if (bus.key_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_empty got valid=%b code=%0d exp valid=0", name, bus.key_valid, bus.key_code);
        end
        bus.ovf_clr = 1'b1;
        @(negedge clk);
        bus.ovf_clr = 1'b0;
        m_ovf = 1'b0;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (filas !== 4'b0 || bus.key_valid !== 1'b0 || bus.key_code !== 5'd0 ||
                bus.overflow !== 1'b0 || bus.irq !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs got filas=%b valid=%b code=%0d ovf=%b irq=%b exp all zero",
                         filas, bus.key_valid, bus.key_code, bus.overflow, bus.irq);
            end
        end
    endtask

    task automatic test_scan();
        logic [3:0] exp;
        int p;
        do_reset();
        enable = 1'b1;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            p   = c % (4 * SD + 16);
            exp = (p < 4 * SD) ? 4'(1 << (p / SD)) : 4'b0000;
            checks++;
            if (filas !== exp || bus.key_valid !== 1'b0) begin
                errors++;
                $display("FAIL scan_filas cycle %0d got %b valid=%b exp %b valid=0", c, filas, bus.key_valid, exp);
            end
        end
    endtask

    task automatic test_single_press();
        do_reset();
        enable = 1'b1;
        do_frame(16'h0040, 1'b0);
        do_frame(16'h0040, 1'b0);
        repeat (15) @(negedge clk);
        checks++;
        if (bus.key_valid !== 1'b1 || bus.key_code !== 5'd6 || bus.irq !== 1'b1) begin
            errors++;
            $display("FAIL single_press got valid=%b code=%0d irq=%b exp 1/6/1", bus.key_valid, bus.key_code, bus.irq);
        end
        for (int i = 0; i < 3; i++) do_frame(16'h0040, 1'b0);
        drain("single_hold");
    endtask

    task automatic test_glitch();
        do_reset();
        enable = 1'b1;
        do_frame(16'h0001, 1'b0);
        do_frame(16'h0000, 1'b0);
        do_frame(16'h0000, 1'b0);
        repeat (15) @(negedge clk);
        checks++;
        if (bus.key_valid !== 1'b0) begin
            errors++;
            $display("FAIL glitch_no_event got valid=%b code=%0d exp valid=0", bus.key_valid, bus.key_code);
        end
        do_frame(16'h0001, 1'b0);
        do_frame(16'h0001, 1'b0);
        repeat (16) @(negedge clk);
        checks++;
        if (bus.key_valid !== 1'b1 || bus.key_code !== 5'd1) begin
            errors++;
            $display("FAIL glitch_stable_kept got valid=%b code=%0d exp 1/1", bus.key_valid, bus.key_code);
        end
        drain("glitch");
    endtask

    task automatic test_two_keys();
        do_reset();
        enable = 1'b1;
        do_frame(16'h8001, 1'b0);
        do_frame(16'h8001, 1'b0);
        checks++;
        if (bus.key_valid !== 1'b0) begin
            errors++;
            $display("FAIL push_latency_early got valid=%b exp 0", bus.key_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.key_valid !== 1'b1 || bus.key_code !== 5'd1) begin
            errors++;
            $display("FAIL push_latency got valid=%b code=%0d exp 1/1", bus.key_valid, bus.key_code);
        end
        repeat (16) @(negedge clk);
        bus.key_pop = 1'b1;
        @(negedge clk);
        bus.key_pop = 1'b0;
        checks++;
        if (bus.key_valid !== 1'b1 || bus.key_code !== 5'd13) begin
            errors++;
            $display("FAIL two_keys_second got valid=%b code=%0d exp 1/13", bus.key_valid, bus.key_code);
        end
        bus.key_pop = 1'b1;
        @(negedge clk);
        bus.key_pop = 1'b0;
        checks++;
        if (bus.key_valid !== 1'b0) begin
            errors++;
            $display("FAIL two_keys_empty got valid=%b exp 0", bus.key_valid);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] h;
        do_reset();
        enable = 1'b1;
        h = '0;
        for (int i = 1; i <= 5; i++) begin
            h[i] = 1'b1;
            do_frame(h, 1'b0);
            do_frame(h, 1'b0);
        end
        repeat (5) @(negedge clk);
        bus.ovf_clr = 1'b1;
        @(negedge clk);
        bus.ovf_clr = 1'b0;
        checks++;
        if (bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set_wins got %b exp 1", bus.overflow);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (bus.key_valid !== 1'b1 || bus.key_code !== 5'd2) begin
            errors++;
            $display("FAIL ovf_head got valid=%b code=%0d exp 1/2", bus.key_valid, bus.key_code);
        end
        bus.ovf_clr = 1'b1;
        @(negedge clk);
        bus.ovf_clr = 1'b0;
        m_ovf = 1'b0;
        checks++;
        if (bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear got %b exp 0", bus.overflow);
        end
        do_frame(16'h0000, 1'b0);
        do_frame(16'h0000, 1'b0);
        do_frame(16'h0001, 1'b0);
        do_frame(16'h0001, 1'b1);
        checks++;
        if (bus.key_code !== 5'd3 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_push_pop got code=%0d ovf=%b exp 3/0", bus.key_code, bus.overflow);
        end
        drain("full_push_pop");
    endtask

    task automatic test_enable_drop();
        do_reset();
        enable = 1'b1;
        do_frame(16'h0040, 1'b0);
        do_frame(16'h0040, 1'b0);
        repeat (17) @(negedge clk);
        wait_filas(4'b0100);
        @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (filas !== 4'b0000 || bus.key_valid !== 1'b1 || bus.key_code !== 5'd6) begin
                errors++;
                $display("FAIL enable_drop got filas=%b valid=%b code=%0d exp 0000/1/6", filas, bus.key_valid, bus.key_code);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.key_valid !== 1'b0 || bus.key_code !== 5'd0 || bus.irq !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got valid=%b code=%0d irq=%b exp 0/0/0", bus.key_valid, bus.key_code, bus.irq);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [15:0] h;
        do_reset();
        h = '0;
        for (int r = 0; r < 3; r++) begin
            enable = 1'b1;
            for (int f = 0; f < 12; f++) begin
                if ($urandom_range(0, 1) == 0) begin
                    h = 16'($urandom) & 16'($urandom) & 16'($urandom);
                end
                do_frame(h, 1'b0);
            end
            drain("random");
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        enable      = 1'b0;
        held        = '0;
        bus.key_pop = 1'b0;
        bus.ovf_clr = 1'b0;
        test_reset();
        test_scan();
        test_single_press();
        test_glitch();
        test_two_keys();
        test_overflow();
        test_enable_drop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
